// File: rtl/collision_scorer_if.sv
// Bus between the game front-end (obstacle/bird/button) and the collision scorer.
// master drives geometry and start; slave returns collision, state and scores.
interface collision_scorer_if;
   logic        start;
   logic [9:0]  obs_x;
   logic [8:0]  obs_ytop;
   logic [8:0]  obs_ybot;
   logic [8:0]  bird_y;
   logic        collision;
   logic        running;
   logic        game_over;
   logic [15:0] score;
   logic [15:0] high_score;

   modport master (
      output start, obs_x, obs_ytop, obs_ybot, bird_y,
      input  collision, running, game_over, score, high_score
   );

   modport slave (
      input  start, obs_x, obs_ytop, obs_ybot, bird_y,
      output collision, running, game_over, score, high_score
   );
endinterface

// File: rtl/collision_scorer.sv
// Collision detection, game-state FSM and BCD score / high score keeper.
// Collision is a two-register pipeline: geometry terms, then the combined hit.
module collision_scorer #(
   parameter int BIRD_X    = 100,
   parameter int BIRD_SIZE = 16,
   parameter int PIPE_W    = 40,
   parameter int SCREEN_H  = 480
) (
   input  logic               clk,
   input  logic               reset,
   collision_scorer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;

   // 11-bit working width keeps x+PIPE_W and y+BIRD_SIZE from wrapping
   localparam logic [10:0] BX = 11'(BIRD_X);
   localparam logic [10:0] BS = 11'(BIRD_SIZE);
   localparam logic [10:0] PW = 11'(PIPE_W);
   localparam logic [10:0] SH = 11'(SCREEN_H);

   state_t      state, state_nx;
   logic [10:0] x_w, ytop_w, ybot_w, by_w;
   logic        ov_d, vt_d, bd_d;
   logic        ov_q, vt_q, bd_q;
   logic        coll_d, coll_q;
   logic        pass, new_obs;
   logic        scored;
   logic [9:0]  prev_x;
   logic [15:0] score_q, high_q;

   assign x_w    = {1'b0, bus.obs_x};
   assign ytop_w = {2'b0, bus.obs_ytop};
   assign ybot_w = {2'b0, bus.obs_ybot};
   assign by_w   = {2'b0, bus.bird_y};

   // Geometry terms; edge pixels count as overlap
   assign ov_d = (BX + BS - 11'd1 >= x_w) && (BX <= x_w + PW - 11'd1);
   assign vt_d = (by_w < ytop_w) || (by_w + BS - 11'd1 >= SH - ybot_w);
   assign bd_d = (by_w + BS - 11'd1 >= SH) || (by_w == 11'd0);

   // Pipe fully left of the bird / a fresh pipe entered from the right
   assign pass    = (x_w + PW - 11'd1) < BX;
   assign new_obs = bus.obs_x > prev_x;

   // +1 in BCD with per-digit carry, saturating at 9999
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      if (v == 16'h9999) return v;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
            else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Stage 1: register the raw geometry terms
   always_ff @(posedge clk) begin
      if (!reset) begin
         ov_q <= 1'b0;
         vt_q <= 1'b0;
         bd_q <= 1'b0;
      end else begin
         ov_q <= ov_d;
         vt_q <= vt_d;
         bd_q <= bd_d;
      end
   end

   // Stage 2 input: hit only counts in PLAY; sticky once raised so DEAD sees 1
   always_comb begin
      coll_d = 1'b0;
      case (state)
         PLAY:    coll_d = coll_q | ((ov_q && vt_q) || bd_q);
         DEAD:    coll_d = !bus.start;
         default: coll_d = 1'b0;
      endcase
   end

   // Stage 2: registered collision flag
   always_ff @(posedge clk) begin
      if (!reset) coll_q <= 1'b0;
      else        coll_q <= coll_d;
   end

   // Game-state register
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state; collision beats start in PLAY, start is ignored there
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = PLAY;
         PLAY:    if (coll_q)    state_nx = DEAD;
         DEAD:    if (bus.start) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Score, scored flag, previous x and high score
   always_ff @(posedge clk) begin
      if (!reset) begin
         score_q <= 16'h0000;
         high_q  <= 16'h0000;
         scored  <= 1'b0;
         prev_x  <= 10'd0;
      end else begin
         prev_x <= bus.obs_x;
         if (state == IDLE && bus.start) begin
            score_q <= 16'h0000;
         end else if (state == PLAY) begin
            // a new pipe re-arms scoring and suppresses a same-cycle pass
            if (new_obs) scored <= 1'b0;
            else if (pass && !scored) begin
               score_q <= bcd_inc(score_q);
               scored  <= 1'b1;
            end
         end
         // BCD ordering matches binary ordering, so a plain compare works
         if (state == PLAY && coll_q && score_q > high_q) high_q <= score_q;
      end
   end

   assign bus.collision  = coll_q;
   assign bus.running    = (state == PLAY);
   assign bus.game_over  = (state == DEAD);
   assign bus.score      = score_q;
   assign bus.high_score = high_q;

endmodule

// File: tb/tb_collision_scorer.sv
// Bench for collision_scorer: a cycle model pushes expected outputs per edge,
// the sample after each edge pops and compares; directed checks add anchors.
module tb_collision_scorer;

   localparam int BX = 100;
   localparam int BS = 16;
   localparam int PW = 40;
   localparam int SH = 480;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   collision_scorer_if bus();

   collision_scorer #(.BIRD_X(BX), .BIRD_SIZE(BS), .PIPE_W(PW), .SCREEN_H(SH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        coll;
      logic        run;
      logic        go;
      logic [15:0] sc;
      logic [15:0] hi;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   // model state: 0 idle, 1 play, 2 dead; scores kept as decimal integers
   int m_st = 0, m_sc = 0, m_hi = 0, m_px = 0;
   bit m_coll = 0, m_ov = 0, m_vt = 0, m_bd = 0, m_scored = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic step(input bit rn, input bit st, input int x, input int yt, input int yb, input int by);
      exp_t e;
      bit   ov, vt, bd, hit, ncoll, nw, ps;
      int   nst;
      reset        = rn;
      bus.start    = st;
      bus.obs_x    = 10'(x);
      bus.obs_ytop = 9'(yt);
      bus.obs_ybot = 9'(yb);
      bus.bird_y   = 9'(by);
      if (!rn) begin
         m_st = 0; m_sc = 0; m_hi = 0; m_px = 0;
         m_coll = 0; m_ov = 0; m_vt = 0; m_bd = 0; m_scored = 0;
      end else begin
         ov    = (BX + BS - 1 >= x) && (BX <= x + PW - 1);
         vt    = (by < yt) || (by + BS - 1 >= SH - yb);
         bd    = (by + BS - 1 >= SH) || (by == 0);
         hit   = (m_ov && m_vt) || m_bd;
         nw    = x > m_px;
         ps    = (x + PW - 1) < BX;
         nst   = m_st;
         ncoll = 0;
         if (m_st == 0) begin
            if (st) begin nst = 1; m_sc = 0; end
         end else if (m_st == 1) begin
            ncoll = m_coll || hit;
            if (m_coll) begin
               nst = 2;
               if (m_sc > m_hi) m_hi = m_sc;
            end
            if (nw) m_scored = 0;
            else if (ps && !m_scored) begin
               if (m_sc < 9999) m_sc = m_sc + 1;
               m_scored = 1;
            end
         end else begin
            ncoll = !st;
            if (st) nst = 0;
         end
         m_st = nst; m_coll = ncoll;
         m_ov = ov; m_vt = vt; m_bd = bd; m_px = x;
      end
      e.coll = m_coll;
      e.run  = (m_st == 1);
      e.go   = (m_st == 2);
      e.sc   = to_bcd(m_sc);
      e.hi   = to_bcd(m_hi);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("collision",  32'(bus.collision),  32'(e.coll));
      chk("running",    32'(bus.running),    32'(e.run));
      chk("game_over",  32'(bus.game_over),  32'(e.go));
      chk("score",      32'(bus.score),      32'(e.sc));
      chk("high_score", 32'(bus.high_score), 32'(e.hi));
   endtask

   // idle-safe geometry: pipe gap 150..329, bird at 200
   task automatic go(input bit st, input int x, input int by);
      step(1'b1, st, x, 150, 150, by);
   endtask

   initial begin
      bus.start = 1'b0; bus.obs_x = '0; bus.obs_ytop = '0; bus.obs_ybot = '0; bus.bird_y = '0;

      // reset
      repeat (3) step(1'b0, 1'b0, 140, 150, 150, 200);
      chk("rst_collision", 32'(bus.collision), 32'd0);
      chk("rst_running",   32'(bus.running),   32'd0);
      chk("rst_game_over", 32'(bus.game_over), 32'd0);
      chk("rst_score",     32'(bus.score),     32'h0);
      chk("rst_high",      32'(bus.high_score), 32'h0);
      go(1'b0, 140, 200);
      go(1'b1, 140, 200);
      chk("start_running", 32'(bus.running), 32'd1);

      // clear pass through the gap, scoring once at x==60
      for (int x = 140; x >= 0; x--) begin
         go(1'b0, x, 200);
         if (x == 61) chk("score_before_pass", 32'(bus.score), 32'h0);
         if (x == 60) chk("score_at_pass", 32'(bus.score), 32'h1);
      end
      chk("clear_no_coll", 32'(bus.collision), 32'd0);
      chk("score_once",    32'(bus.score),     32'h1);

      // top-pipe hit: two-edge collision latency, then DEAD
      go(1'b0, 90, 140);
      chk("top_lat1", 32'(bus.collision), 32'd0);
      go(1'b0, 90, 140);
      chk("top_lat2", 32'(bus.collision), 32'd1);
      chk("top_not_dead_yet", 32'(bus.game_over), 32'd0);
      go(1'b0, 90, 140);
      chk("top_dead", 32'(bus.game_over), 32'd1);
      chk("top_high", 32'(bus.high_score), 32'h1);
      go(1'b0, 500, 200);
      chk("dead_hold", 32'(bus.collision), 32'd1);

      // restart: DEAD -> IDLE -> PLAY
      go(1'b1, 500, 200);
      chk("restart_coll", 32'(bus.collision), 32'd0);
      chk("restart_idle", 32'(bus.running), 32'd0);
      go(1'b0, 500, 200);
      go(1'b1, 500, 200);
      chk("restart_score", 32'(bus.score), 32'h0);
      chk("restart_high",  32'(bus.high_score), 32'h1);

      // floor bound: 464 keeps the bottom row at 479, 465 reaches 480
      repeat (3) go(1'b0, 500, 464);
      chk("floor_464", 32'(bus.collision), 32'd0);
      go(1'b0, 500, 465);
      go(1'b0, 500, 465);
      chk("floor_465", 32'(bus.collision), 32'd1);
      go(1'b0, 500, 200);
      chk("floor_dead", 32'(bus.game_over), 32'd1);

      // bottom-pipe edge at y=330
      go(1'b1, 90, 200);
      step(1'b1, 1'b1, 90, 150, 150, 314);
      repeat (3) step(1'b1, 1'b0, 90, 150, 150, 314);
      chk("bot_314", 32'(bus.collision), 32'd0);
      step(1'b1, 1'b0, 90, 150, 150, 315);
      step(1'b1, 1'b0, 90, 150, 150, 315);
      chk("bot_315", 32'(bus.collision), 32'd1);

      // new obstacle coinciding with pass gives no increment
      go(1'b0, 600, 200);
      go(1'b1, 600, 200);
      go(1'b0, 600, 200);
      go(1'b1, 600, 200);
      go(1'b0, 0, 200);
      chk("pass_inc", 32'(bus.score), 32'h1);
      go(1'b0, 20, 200);
      chk("newobs_wins", 32'(bus.score), 32'h1);
      go(1'b0, 10, 200);
      chk("rearmed_inc", 32'(bus.score), 32'h2);

      // saturation
      for (int i = 0; i < 10000; i++) begin
         go(1'b0, 600, 200);
         go(1'b0, 0, 200);
      end
      chk("saturate", 32'(bus.score), 32'h9999);

      // ceiling bound (bird_y==0) with a top score
      go(1'b0, 0, 0);
      go(1'b0, 0, 200);
      chk("ceil_coll", 32'(bus.collision), 32'd1);
      go(1'b0, 0, 200);
      chk("ceil_high", 32'(bus.high_score), 32'h9999);

      // restart keeps high score, then mid-game reset
      go(1'b1, 600, 200);
      go(1'b1, 600, 200);
      chk("keep_high", 32'(bus.high_score), 32'h9999);
      chk("new_score", 32'(bus.score), 32'h0);
      go(1'b0, 600, 200);
      go(1'b0, 0, 200);
      step(1'b0, 1'b1, 90, 150, 150, 0);
      chk("midrst_run",   32'(bus.running),    32'd0);
      chk("midrst_score", 32'(bus.score),      32'h0);
      chk("midrst_high",  32'(bus.high_score), 32'h0);
      go(1'b0, 600, 200);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
